// File: rtl/tap_ir_dr_ctrl.sv
// JTAG IR/DR stage: IR shift/update pair, BYPASS + IDCODE DRs, optional USER DR (TAP_USER_DR_EN), negedge-retimed TDO.
// Latency tdi->tdo in SHIFT: BYPASS 1, IDCODE 32, USER USER_W, IR IR_WIDTH tck; no backpressure, paced by tap_state.
module tap_ir_dr_ctrl #(
  parameter int          IR_WIDTH   = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1234_5001,
  parameter int          USER_W     = 16
) (
  input  logic                tck,
  input  logic                trst_n,
  input  logic [15:0]         tap_state,
  input  logic                tdi,
  output logic                tdo,
  output logic                tdo_oe,
  output logic [IR_WIDTH-1:0] ir_out,
  output logic [USER_W-1:0]   user_dr_out,
  input  logic [USER_W-1:0]   user_dr_in,
  output logic                user_update
);

  localparam logic [IR_WIDTH-1:0] OP_IDCODE  = {{(IR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [IR_WIDTH-1:0] OP_USER    = {{(IR_WIDTH-2){1'b0}}, 2'b10};
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-1){1'b0}}, 1'b1};

  // A corrupted state bus (none or several bits) must freeze everything.
  logic st_valid;
  assign st_valid = (tap_state != 16'd0) && ((tap_state & (tap_state - 16'd1)) == 16'd0);

  logic s_tlr, s_cap_dr, s_shift_dr, s_upd_dr, s_cap_ir, s_shift_ir, s_upd_ir;
  assign s_tlr      = st_valid & tap_state[0];
  assign s_cap_dr   = st_valid & tap_state[3];
  assign s_shift_dr = st_valid & tap_state[4];
  assign s_upd_dr   = st_valid & tap_state[8];
  assign s_cap_ir   = st_valid & tap_state[10];
  assign s_shift_ir = st_valid & tap_state[11];
  assign s_upd_ir   = st_valid & tap_state[15];

  logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
  logic [IR_WIDTH-1:0] ir_out_q, ir_out_d;
  logic                bypass_q, bypass_d;
  logic [31:0]         id_shift_q, id_shift_d;
  logic                tdo_q, tdo_d;
  logic                tdo_oe_q, tdo_oe_d;

  logic sel_id, sel_user, sel_byp;
  logic user_lsb;

  assign sel_id  = (ir_out_q == OP_IDCODE);
  assign sel_byp = !sel_id && !sel_user;

  // Instruction register: shift stage and the live (updated) instruction.
  always_comb begin
    ir_shift_d = ir_shift_q;
    ir_out_d   = ir_out_q;
    if (s_cap_ir) begin
      ir_shift_d = IR_CAPTURE;
    end else if (s_shift_ir) begin
      ir_shift_d = {tdi, ir_shift_q[IR_WIDTH-1:1]};
    end
    if (s_tlr) begin
      ir_out_d = OP_IDCODE;
    end else if (s_upd_ir) begin
      ir_out_d = ir_shift_q;
    end
  end

  always_comb begin
    bypass_d   = bypass_q;
    id_shift_d = id_shift_q;
    if (sel_byp) begin
      if (s_cap_dr) begin
        bypass_d = 1'b0;
      end else if (s_shift_dr) begin
        bypass_d = tdi;
      end
    end
    if (sel_id) begin
      if (s_cap_dr) begin
        id_shift_d = IDCODE_VAL;
      end else if (s_shift_dr) begin
        id_shift_d = {tdi, id_shift_q[31:1]};
      end
    end
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      ir_shift_q <= '0;
      ir_out_q   <= OP_IDCODE;
      bypass_q   <= 1'b0;
      id_shift_q <= '0;
    end else begin
      ir_shift_q <= ir_shift_d;
      ir_out_q   <= ir_out_d;
      bypass_q   <= bypass_d;
      id_shift_q <= id_shift_d;
    end
  end

`ifdef TAP_USER_DR_EN
  logic [USER_W-1:0] user_shift_q, user_shift_d;
  logic [USER_W-1:0] user_out_q, user_out_d;
  logic              user_upd_q, user_upd_d;

  assign sel_user = (ir_out_q == OP_USER);
  assign user_lsb = user_shift_q[0];

  always_comb begin
    user_shift_d = user_shift_q;
    user_out_d   = user_out_q;
    user_upd_d   = 1'b0;
    if (sel_user) begin
      if (s_cap_dr) begin
        user_shift_d = user_dr_in;
      end else if (s_shift_dr) begin
        user_shift_d = {tdi, user_shift_q[USER_W-1:1]};
      end
      if (s_upd_dr) begin
        user_out_d = user_shift_q;
        user_upd_d = 1'b1;
      end
    end
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      user_shift_q <= '0;
      user_out_q   <= '0;
      user_upd_q   <= 1'b0;
    end else begin
      user_shift_q <= user_shift_d;
      user_out_q   <= user_out_d;
      user_upd_q   <= user_upd_d;
    end
  end

  assign user_dr_out = user_out_q;
  assign user_update = user_upd_q;
`else
  logic unused_user_in;
  assign unused_user_in = ^user_dr_in;
  assign sel_user    = 1'b0;
  assign user_lsb    = 1'b0;
  assign user_dr_out = '0;
  assign user_update = 1'b0;
`endif

  // TDO is retimed to the falling edge so the probe samples it on the next rising edge.
  always_comb begin
    tdo_d    = tdo_q;
    tdo_oe_d = 1'b0;
    if (s_shift_ir) begin
      tdo_d    = ir_shift_q[0];
      tdo_oe_d = 1'b1;
    end else if (s_shift_dr) begin
      tdo_d    = sel_id ? id_shift_q[0] : (sel_user ? user_lsb : bypass_q);
      tdo_oe_d = 1'b1;
    end
  end

  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_oe_q <= tdo_oe_d;
    end
  end

  assign tdo    = tdo_q;
  assign tdo_oe = tdo_oe_q;
  assign ir_out = ir_out_q;

endmodule

// File: tb/tb_tap_ir_dr_ctrl.sv
// Bench for tap_ir_dr_ctrl: drives tap_state directly, checks every cycle against a queue-based DR/IR model.
module tb_tap_ir_dr_ctrl;
  localparam int          IRW = 4;
  localparam int          UW  = 16;
  localparam logic [31:0] IDC = 32'h1234_5001;
`ifdef TAP_USER_DR_EN
  localparam bit USER_EN = 1'b1;
`else
  localparam bit USER_EN = 1'b0;
`endif

  localparam logic [15:0] S_TLR = 16'h0001, S_RTI = 16'h0002, S_SEL_DR = 16'h0004,
                          S_CAP_DR = 16'h0008, S_SHIFT_DR = 16'h0010, S_EXIT1_DR = 16'h0020,
                          S_PAUSE_DR = 16'h0040, S_EXIT2_DR = 16'h0080, S_UPD_DR = 16'h0100,
                          S_SEL_IR = 16'h0200, S_CAP_IR = 16'h0400, S_SHIFT_IR = 16'h0800,
                          S_EXIT1_IR = 16'h1000, S_PAUSE_IR = 16'h2000, S_EXIT2_IR = 16'h4000,
                          S_UPD_IR = 16'h8000;

  logic           tck = 1'b0;
  logic           trst_n;
  logic [15:0]    tap_state;
  logic           tdi;
  logic           tdo, tdo_oe;
  logic [IRW-1:0] ir_out;
  logic [UW-1:0]  user_dr_out, user_dr_in;
  logic           user_update;

  tap_ir_dr_ctrl #(.IR_WIDTH(IRW), .IDCODE_VAL(IDC), .USER_W(UW)) dut (
    .tck(tck), .trst_n(trst_n), .tap_state(tap_state), .tdi(tdi), .tdo(tdo), .tdo_oe(tdo_oe),
    .ir_out(ir_out), .user_dr_out(user_dr_out), .user_dr_in(user_dr_in), .user_update(user_update)
  );

  always #5 tck = ~tck;

  int checks = 0, errors = 0, upd_seen = 0;
  bit chk_en = 1'b0;

  // Model: each register is a bit queue, LSB at the front; a shift pops the front, pushes tdi.
  bit irq[$], bypq[$], idq[$], usrq[$];
  int m_ir_out, m_user_out;
  bit m_tdo, m_oe, m_upd;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic load_q(input int s, input logic [31:0] v, input int w);
    bit t[$];
    for (int i = 0; i < w; i++) t.push_back(v[i]);
    case (s)
      0: bypq = t;
      1: idq = t;
      2: usrq = t;
      default: irq = t;
    endcase
  endtask

  function automatic bit front(input int s);
    case (s)
      0: return bypq[0];
      1: return idq[0];
      2: return usrq[0];
      default: return irq[0];
    endcase
  endfunction

  task automatic shift_q(input int s, input bit d);
    case (s)
      0: begin void'(bypq.pop_front()); bypq.push_back(d); end
      1: begin void'(idq.pop_front()); idq.push_back(d); end
      2: begin void'(usrq.pop_front()); usrq.push_back(d); end
      default: begin void'(irq.pop_front()); irq.push_back(d); end
    endcase
  endtask

  function automatic int pack(input int s);
    int v = 0;
    if (s == 2) begin
      for (int i = 0; i < usrq.size(); i++) if (usrq[i]) v |= (1 << i);
    end else begin
      for (int i = 0; i < irq.size(); i++) if (irq[i]) v |= (1 << i);
    end
    return v;
  endfunction

  function automatic int msel();
    if (m_ir_out == 1) return 1;
    if (USER_EN && m_ir_out == 2) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    load_q(3, 0, IRW); load_q(0, 0, 1); load_q(1, 0, 32); load_q(2, 0, UW);
    m_ir_out = 1; m_user_out = 0; m_upd = 0; m_tdo = 0; m_oe = 0;
  endtask

  // One TAP cycle: inputs driven just after posedge, model advanced on the next posedge.
  task automatic step(input logic [15:0] st, input logic d);
    bit ok;
    int s;
    tap_state = st;
    tdi = d;
    ok = trst_n && ($countones(st) == 1);
    s = msel();
    if (trst_n) begin
      m_oe = 1'b0;
      if (ok && st == S_SHIFT_IR) begin m_tdo = irq[0]; m_oe = 1'b1; end
      else if (ok && st == S_SHIFT_DR) begin m_tdo = front(s); m_oe = 1'b1; end
    end
    @(posedge tck);
    if (trst_n) begin
      m_upd = 1'b0;
      if (ok) begin
        case (st)
          S_TLR:      m_ir_out = 1;
          S_CAP_IR:   load_q(3, 1, IRW);
          S_SHIFT_IR: shift_q(3, d);
          S_UPD_IR:   m_ir_out = pack(3);
          S_CAP_DR:   load_q(s, (s == 1) ? IDC : (s == 2) ? 32'(user_dr_in) : 32'd0,
                             (s == 1) ? 32 : (s == 2) ? UW : 1);
          S_SHIFT_DR: shift_q(s, d);
          S_UPD_DR:   if (s == 2) begin m_user_out = pack(2); m_upd = 1'b1; end
          default: ;
        endcase
      end
    end
    #1;
  endtask

  always @(negedge tck) begin
    #1;
    if (chk_en) begin
      check("tdo", 32'(tdo), 32'(m_tdo));
      check("tdo_oe", 32'(tdo_oe), 32'(m_oe));
      check("ir_out", 32'(ir_out), m_ir_out);
      check("user_dr_out", 32'(user_dr_out), m_user_out);
      check("user_update", 32'(user_update), 32'(m_upd));
      if (user_update) upd_seen++;
    end
  end

  // glitch=1 replaces the pause detour with two non-one-hot cycles.
  task automatic dr_scan(input int n, input logic [31:0] din, input int pause_at, input bit glitch,
                         output logic [31:0] dout);
    dout = '0;
    step(S_SEL_DR, 0); step(S_CAP_DR, 0);
    for (int i = 0; i < n; i++) begin
      if (i == pause_at) begin
        if (glitch) begin
          step(16'h0000, 1); step(16'h0018 | 16'($urandom), 1);
        end else begin
          step(S_EXIT1_DR, 0); step(S_PAUSE_DR, 1); step(S_PAUSE_DR, 0); step(S_EXIT2_DR, 1);
        end
      end
      step(S_SHIFT_DR, din[i]);
      dout[i] = tdo;
    end
    step(S_EXIT1_DR, 0); step(S_UPD_DR, 0); step(S_RTI, 0);
  endtask

  task automatic ir_scan(input logic [IRW-1:0] op, input int pause_at, output logic [IRW-1:0] dout);
    dout = '0;
    step(S_SEL_DR, 0); step(S_SEL_IR, 0); step(S_CAP_IR, 0);
    for (int i = 0; i < IRW; i++) begin
      if (i == pause_at) begin
        step(S_EXIT1_IR, 1); step(S_PAUSE_IR, 0); step(S_PAUSE_IR, 1); step(S_EXIT2_IR, 0);
      end
      step(S_SHIFT_IR, op[i]);
      dout[i] = tdo;
    end
    step(S_EXIT1_IR, 0); step(S_UPD_IR, 0); step(S_RTI, 0);
  endtask

  task automatic do_reset(input logic [15:0] st);
    trst_n = 1'b0;
    model_reset();
    step(st, 1); step(st, 1); step(S_UPD_DR, 0);
    check("rst_ir_out", 32'(ir_out), 32'h1);
    check("rst_user_dr_out", 32'(user_dr_out), 32'h0);
    check("rst_user_update", 32'(user_update), 32'h0);
    check("rst_tdo_oe", 32'(tdo_oe), 32'h0);
    check("rst_tdo", 32'(tdo), 32'h0);
    trst_n = 1'b1;
    step(S_TLR, 0); step(S_RTI, 0);
  endtask

  initial begin
    logic [31:0]    dd;
    logic [IRW-1:0] io;
    int             u0;
    trst_n = 1'b0; tap_state = S_TLR; tdi = 1'b0; user_dr_in = 16'hA5C3;
    model_reset();
    #1;
    chk_en = 1'b1;
    do_reset(S_TLR);

    dr_scan(32, 32'($urandom), -1, 0, dd);
    check("t1_idcode_stream", dd, IDC);

    ir_scan(4'hF, -1, io);
    check("t2_ir_capture", 32'(io), 32'h1);
    check("t2_ir_out", 32'(ir_out), 32'hF);
    dr_scan(4, 32'b1101, -1, 0, dd);
    check("t2_bypass_stream", 32'(dd[3:0]), 32'hA);

    user_dr_in = 16'hA5C3;
    ir_scan(4'h2, -1, io);
    u0 = upd_seen;
    dr_scan(16, 32'h1234, -1, 0, dd);
    check("t3_user_stream", 32'(dd[15:0]), USER_EN ? 32'hA5C3 : 32'h2468);
    check("t3_user_dr_out", 32'(user_dr_out), USER_EN ? 32'h1234 : 32'h0);
    check("t3_update_pulses", upd_seen - u0, USER_EN ? 32'd1 : 32'd0);

    ir_scan(4'h7, -1, io);
    check("t4_ir_out", 32'(ir_out), 32'h7);
    dr_scan(4, 32'b0110, -1, 0, dd);
    check("t4_bypass_stream", 32'(dd[3:0]), 32'hC);

    ir_scan(4'h6, 2, io);
    check("t5_ir_capture", 32'(io), 32'h1);
    check("t5_ir_out", 32'(ir_out), 32'h6);

    ir_scan(4'h2, -1, io);
    u0 = upd_seen;
    step(S_SEL_DR, 0); step(S_CAP_DR, 0);
    for (int i = 0; i < 5; i++) step(S_SHIFT_DR, 1'($urandom));
    do_reset(S_SHIFT_DR);
    check("t6_no_update", upd_seen - u0, 32'd0);

    for (int it = 0; it < 40; it++) begin
      user_dr_in = 16'($urandom);
      case ($urandom_range(0, 4))
        0: begin
          case ($urandom_range(0, 3))
            0: io = 4'h1;
            1: io = 4'h2;
            2: io = 4'hF;
            default: io = 4'($urandom);
          endcase
          ir_scan(io, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, IRW - 1)) : -1, io);
        end
        1, 2, 3: begin
          int n;
          n = $urandom_range(1, 32);
          dr_scan(n, $urandom, (n > 1) ? int'($urandom_range(1, n - 1)) : -1, 1'($urandom), dd);
        end
        default: begin
          step(16'h0000, 1'($urandom));
          step(16'h8400 | 16'($urandom), 1'($urandom));
          if ($urandom_range(0, 1) == 1) step(S_TLR, 0);
          step(S_RTI, 0);
        end
      endcase
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
